// File: rtl/sdram_wr_fifo_if.sv
// Bundle of UART-side and SDRAM-write-stage signals for sdram_wr_fifo_ctrl.
// The slave modport is the controller; the master modport is whatever drives it.
interface sdram_wr_fifo_if #(
  parameter int LEVEL_W = 10
);
  logic               init_end;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               wr_ack;
  logic               wr_end;
  logic               wr_en;
  logic [23:0]        wr_addr;
  logic [15:0]        wr_data;
  logic [9:0]         wr_burst_len;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overflow;

  modport master (
    output init_end, rx_data, rx_valid, wr_ack, wr_end,
    input  wr_en, wr_addr, wr_data, wr_burst_len, fifo_level, overflow
  );

  modport slave (
    input  init_end, rx_data, rx_valid, wr_ack, wr_end,
    output wr_en, wr_addr, wr_data, wr_burst_len, fifo_level, overflow
  );
endinterface

// File: rtl/sdram_wr_fifo_ctrl.sv
// Packs UART bytes into 16-bit words, buffers them in a synchronous FIFO and
// hands them to the SDRAM write stage one burst at a time.
module sdram_wr_fifo_ctrl #(
  parameter logic [9:0]  BURST_LEN  = 10'd10,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [23:0] ADDR_BASE  = 24'h00_0000,
  parameter logic [23:0] ADDR_LIMIT = 24'h00_0400
) (
  input logic          clk,
  input logic          rst_n,
  sdram_wr_fifo_if.slave bus
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   DEPTH_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]   BURST_LVL  = LW'(BURST_LEN);
  localparam logic [23:0]     BURST_ADDR = {14'd0, BURST_LEN};

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_BUSY = 3'b100
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            wr_en_r;
  logic            wr_en_s;
  logic [23:0]     wr_addr_r;
  logic [23:0]     wr_addr_s;
  logic [15:0]     wr_data_r;
  logic            phase_r;
  logic [7:0]      low_byte_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            overflow_r;
  logic [15:0]     mem [FIFO_DEPTH];

  logic            push_req_s;
  logic            push_s;
  logic            pop_s;
  logic            drop_s;
  logic            full_s;
  logic            empty_s;
  logic            active_s;

  // Next burst start; wraps early so that the following burst never crosses ADDR_LIMIT.
  function automatic logic [23:0] next_burst_addr(input logic [23:0] addr);
    logic [23:0] far_end;
    far_end = addr + BURST_ADDR + BURST_ADDR;
    if (far_end > ADDR_LIMIT) begin
      next_burst_addr = ADDR_BASE;
    end else begin
      next_burst_addr = addr + BURST_ADDR;
    end
  endfunction

  // FIFO push/pop qualification; a pop frees the slot a same-cycle push needs.
  always_comb begin
    push_req_s = bus.rx_valid & phase_r;
    full_s     = (level_r == DEPTH_LVL);
    empty_s    = (level_r == {LW{1'b0}});
    active_s   = (state_r != ST_IDLE);
    pop_s      = bus.wr_ack & ~empty_s & active_s;
    push_s     = push_req_s & (~full_s | pop_s);
    drop_s     = push_req_s & full_s & ~pop_s;
  end

  // Byte packing, FIFO pointers, level, read data and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r    <= 1'b0;
      low_byte_r <= 8'h00;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      wr_data_r  <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      if (bus.rx_valid) begin
        phase_r <= ~phase_r;
        if (!phase_r) begin
          low_byte_r <= bus.rx_data;
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        wr_data_r <= mem[rd_ptr_r];
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are meaningless after reset because the pointers restart.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= {bus.rx_data, low_byte_r};
    end
  end

  // Burst sequencing: request once a full burst is buffered, advance address on completion.
  always_comb begin
    state_s   = state_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.init_end && (level_r >= BURST_LVL)) begin
          state_s = ST_REQ;
          wr_en_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          wr_en_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.wr_ack) begin
          state_s = ST_BUSY;
          wr_en_s = 1'b0;
        end else begin
          state_s = ST_REQ;
          wr_en_s = 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus.wr_end) begin
          state_s   = ST_IDLE;
          wr_addr_s = next_burst_addr(wr_addr_r);
        end else begin
          state_s   = ST_BUSY;
          wr_addr_s = wr_addr_r;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        wr_en_s   = 1'b0;
        wr_addr_s = ADDR_BASE;
      end
    endcase
  end

  // FSM state and registered request/address outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      wr_en_r   <= 1'b0;
      wr_addr_r <= ADDR_BASE;
    end else begin
      state_r   <= state_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
    end
  end

  assign bus.wr_en        = wr_en_r;
  assign bus.wr_addr      = wr_addr_r;
  assign bus.wr_data      = wr_data_r;
  assign bus.wr_burst_len = BURST_LEN;
  assign bus.fifo_level   = level_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// Randomized bench for sdram_wr_fifo_ctrl against a queue-based reference model.
module tb_sdram_wr_fifo_ctrl;
  localparam logic [9:0]  BL    = 10'd10;
  localparam int          DEPTH = 512;
  localparam int          LW    = 10;
  localparam logic [23:0] BASE  = 24'd0;
  localparam logic [23:0] LIMIT = 24'd30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_wr_fifo_if #(.LEVEL_W(LW)) bus ();

  sdram_wr_fifo_ctrl #(
    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .ADDR_BASE(BASE), .ADDR_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] mq[$];
  bit          m_phase;
  logic [7:0]  m_low;
  bit          m_ovf;
  logic [23:0] m_addr;
  logic [15:0] m_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    mq.delete();
    m_phase = 1'b0; m_low = 8'h00; m_ovf = 1'b0; m_addr = BASE; m_data = 16'h0000;
  endfunction

  // second byte of a pair forms a word; it is kept only if there is room
  function automatic void model_byte(input logic [7:0] b);
    if (!m_phase) begin
      m_low = b; m_phase = 1'b1;
    end else begin
      m_phase = 1'b0;
      if (mq.size() < DEPTH) mq.push_back({b, m_low});
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_next_addr();
    if (int'(m_addr) + 2 * int'(BL) > int'(LIMIT)) m_addr = BASE;
    else m_addr = m_addr + {14'd0, BL};
  endfunction

  task automatic drive_idle();
    bus.init_end = 1'b0; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    bus.wr_ack = 1'b0; bus.wr_end = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    model_clear();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_wr_en();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wr_en === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_wr_en: wr_en never rose within 40 cycles"); end
  endtask

  // one complete burst: request, BL acks, optional ack on empty, wr_end
  task automatic run_burst(input bit drop_init, input bit extra_ack);
    wait_wr_en();
    checks++;
    if (bus.wr_addr !== m_addr) begin errors++; $display("FAIL burst_addr: got %0h expected %0h", bus.wr_addr, m_addr); end
    for (int k = 0; k < int'(BL); k++) begin
      bus.wr_ack = 1'b1;
      if (drop_init && k == 1) bus.init_end = 1'b0;
      tick();
      m_data = mq.pop_front();
      checks++;
      if (bus.wr_data !== m_data) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", k, bus.wr_data, m_data); end
      if (k == 0) begin
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_drop: got %b expected 0", bus.wr_en); end
      end
    end
    if (extra_ack) begin
      tick();
      checks++;
      if (bus.wr_data !== m_data) begin errors++; $display("FAIL empty_ack_hold: got %h expected %h", bus.wr_data, m_data); end
    end
    bus.wr_ack = 1'b0;
    checks++;
    if (bus.fifo_level !== LW'(mq.size())) begin errors++; $display("FAIL burst_level: got %0d expected %0d", bus.fifo_level, mq.size()); end
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    model_next_addr();
    checks++;
    if (bus.wr_addr !== m_addr) begin errors++; $display("FAIL next_addr: got %0h expected %0h", bus.wr_addr, m_addr); end
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_after_end: got %b expected 0", bus.wr_en); end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    model_clear();
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", bus.wr_en); end
    checks++;
    if (bus.wr_addr !== BASE) begin errors++; $display("FAIL rst_wr_addr: got %0h expected %0h", bus.wr_addr, BASE); end
    checks++;
    if (bus.wr_data !== 16'h0000) begin errors++; $display("FAIL rst_wr_data: got %h expected 0000", bus.wr_data); end
    checks++;
    if (bus.fifo_level !== 10'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", bus.fifo_level); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", bus.overflow); end
    checks++;
    if (bus.wr_burst_len !== 10'd10) begin errors++; $display("FAIL burst_len: got %0d expected 10", bus.wr_burst_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pack();
    send_byte(8'h11);
    repeat (3) tick();
    checks++;
    if (bus.fifo_level !== 10'd0) begin errors++; $display("FAIL lone_byte: got %0d expected 0", bus.fifo_level); end
    send_byte(8'h22);
    checks++;
    if (bus.fifo_level !== LW'(mq.size())) begin errors++; $display("FAIL pack_level: got %0d expected %0d", bus.fifo_level, mq.size()); end
    tick();
    checks++;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL pack_no_req: got %b expected 0", bus.wr_en); end
    // wr_end and wr_ack while idle must have no effect
    bus.wr_end = 1'b1; bus.wr_ack = 1'b1;
    tick();
    bus.wr_end = 1'b0; bus.wr_ack = 1'b0;
    checks++;
    if (bus.wr_addr !== m_addr) begin errors++; $display("FAIL idle_wr_end: got %0h expected %0h", bus.wr_addr, m_addr); end
    checks++;
    if (bus.fifo_level !== LW'(mq.size()) || bus.wr_data !== 16'h0000) begin
      errors++; $display("FAIL idle_ack: level %0d data %h expected level %0d data 0000", bus.fifo_level, bus.wr_data, mq.size());
    end
  endtask

  task automatic test_burst();
    apply_reset();
    bus.init_end = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    tick();
    checks++;
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL burst_req: got %b expected 1", bus.wr_en); end
    run_burst(1'b0, 1'b1);
  endtask

  task automatic test_addr_wrap();
    for (int b = 0; b < 4; b++) begin
      send_random(20, 1'b1);
      run_burst(1'b0, 1'b0);
    end
  endtask

  task automatic test_init_gate();
    apply_reset();
    send_random(30, 1'b1);
    repeat (5) tick();
    checks++;
    if (bus.wr_en !== 1'b0 || bus.fifo_level !== LW'(mq.size())) begin
      errors++; $display("FAIL init_gate: wr_en %b level %0d expected 0 and %0d", bus.wr_en, bus.fifo_level, mq.size());
    end
    bus.init_end = 1'b1;
    tick();
    checks++;
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL init_rise: got %b expected 1", bus.wr_en); end
    run_burst(1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] b2;
    apply_reset();
    send_random(2 * DEPTH, 1'b0);
    checks++;
    if (bus.fifo_level !== LW'(DEPTH) || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL fill: level %0d ovf %b expected %0d and 0", bus.fifo_level, bus.overflow, DEPTH);
    end
    send_random(2, 1'b0);
    checks++;
    if (bus.fifo_level !== LW'(DEPTH) || bus.overflow !== m_ovf) begin
      errors++; $display("FAIL overflow: level %0d ovf %b expected %0d and %b", bus.fifo_level, bus.overflow, DEPTH, m_ovf);
    end
    bus.init_end = 1'b1;
    tick();
    send_byte(8'($urandom));
    // second byte lands in the same cycle as the first pop
    b2 = 8'($urandom);
    bus.rx_data = b2; bus.rx_valid = 1'b1; bus.wr_ack = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    m_data = mq.pop_front();
    model_byte(b2);
    checks++;
    if (bus.fifo_level !== LW'(DEPTH) || bus.wr_data !== m_data) begin
      errors++; $display("FAIL push_pop_full: level %0d data %h expected %0d and %h", bus.fifo_level, bus.wr_data, DEPTH, m_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      m_data = mq.pop_front();
      checks++;
      if (bus.wr_data !== m_data) begin errors++; $display("FAIL drain[%0d]: got %h expected %h", i, bus.wr_data, m_data); end
    end
    bus.wr_ack = 1'b0;
    checks++;
    if (bus.fifo_level !== 10'd0 || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL drained: level %0d ovf %b expected 0 and 1", bus.fifo_level, bus.overflow);
    end
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.init_end = 1'b1;
    send_random(40, 1'b0);
    run_burst(1'b0, 1'b0);
    wait_wr_en();
    bus.wr_ack = 1'b1;
    repeat (3) tick();
    bus.wr_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== BASE || bus.fifo_level !== 10'd0 || bus.overflow !== 1'b0 || bus.wr_data !== 16'h0000) begin
      errors++; $display("FAIL async_reset: wr_en %b addr %0h level %0d ovf %b data %h expected all zero",
                         bus.wr_en, bus.wr_addr, bus.fifo_level, bus.overflow, bus.wr_data);
    end
    tick();
    rst_n = 1'b1;
    model_clear();
    tick();
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    tick();
    checks++;
    if (bus.wr_addr !== m_addr || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_end: addr %0h wr_en %b expected %0h and 0", bus.wr_addr, bus.wr_en, m_addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_pack();
    test_burst();
    test_addr_wrap();
    test_init_gate();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_wr_fifo_ctrl.md
Name: sdram_wr_fifo_ctrl

Overview:
- Upstream feeder for the SDRAM write stage in the UART→SDRAM path.
- Packs UART receive bytes into 16-bit words and buffers them in an internal synchronous FIFO.
- Once a full burst is buffered, issues a write request with a burst address, supplies one word per write-acknowledge cycle, and advances the address on write completion.

Parameters:
- BURST_LEN, 10'd10, words per SDRAM write burst; driven on wr_burst_len; 1..FIFO_DEPTH.
- FIFO_DEPTH, 512, FIFO depth in 16-bit words; power of 2.
- ADDR_BASE, 24'h00_0000, first burst address and wrap target.
- ADDR_LIMIT, 24'h00_0400, exclusive upper word-address bound of the write region.

Ports:
- clk  in  1  system clock (SDRAM controller domain)
- rst_n  in  1  reset
- init_end  in  1  SDRAM initialisation complete; level-sensitive
- rx_data  in  8  UART receive byte
- rx_valid  in  1  single-cycle strobe; rx_data valid
- wr_ack  in  1  write stage consuming data; one word per high cycle
- wr_end  in  1  single-cycle strobe; burst fully written and precharged
- wr_en  out  1  write request to write stage
- wr_addr  out  24  burst start address {bank, row, col}
- wr_data  out  16  data word for write stage
- wr_burst_len  out  10  constant BURST_LEN
- fifo_level  out  log2(FIFO_DEPTH)+1  words currently buffered
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values:
  - wr_en=0, wr_addr=ADDR_BASE, wr_data=0, fifo_level=0, overflow=0.
  - Byte-phase flag cleared, FSM in IDLE, FIFO pointers 0.
- Byte packing: on the first rx_valid, rx_data is latched as the low byte [7:0]. On the second rx_valid, the word {rx_data, low} is pushed into the FIFO in that same cycle, and the phase returns to first. A lone first byte is held indefinitely.
- Push when full: the word is discarded, overflow is set (sticky until reset), pointers and level are unchanged, and the byte phase still toggles.
- Pop: each cycle with wr_ack=1 and the FIFO non-empty pops one word. wr_data is registered and updates on the clock edge after the pop cycle, i.e. one cycle after each wr_ack-high cycle. With wr_ack=1 and the FIFO empty there is no pop and wr_data holds.
- Simultaneous push and pop in one cycle: level unchanged, both operations take effect. A push into a full FIFO with a simultaneous pop is accepted (not dropped).
- fifo_level is registered and exact: +1 on push only, -1 on pop only.
- FSM, one-hot, states IDLE, REQ, BUSY:
  - IDLE: when init_end=1 and fifo_level>=BURST_LEN, go to REQ and set wr_en=1 on the same edge.
  - REQ: wr_en held 1 until the first cycle wr_ack=1, then wr_en=0 on the next edge and the FSM moves to BUSY.
  - BUSY: wr_en=0. On wr_end=1, wr_addr <= wr_addr+BURST_LEN, or ADDR_BASE if wr_addr+2*BURST_LEN > ADDR_LIMIT (so the next burst never crosses ADDR_LIMIT); then go to IDLE.
  - Next request no earlier than the cycle after returning to IDLE.
- wr_addr is stable from REQ entry through wr_end.
- wr_end in IDLE or REQ is ignored; wr_ack in IDLE does not pop.
- init_end falling mid-burst does not abort the current burst; it only gates new requests from IDLE.
- 24-bit address arithmetic, carry discarded; wr_burst_len = BURST_LEN[9:0] continuously.
- Reset mid-burst: everything returns to reset values immediately; buffered data is lost.

Test Plan:
- Send bytes 0x11,0x22 -> one push of 16'h2211, fifo_level=1, wr_en stays 0 (BURST_LEN=10).
- init_end=1, send 20 bytes 0x00..0x13 -> wr_en=1 at wr_addr=0. Hold wr_ack 10 cycles -> wr_data sequence 16'h0100,16'h0302,…,16'h1312, each one cycle after its ack; wr_en drops after the first ack; fifo_level=0.
- Pulse wr_end after the burst -> wr_addr=24'd10. Repeat bursts with ADDR_LIMIT=30 -> addresses 0,10,20,0.
- init_end=0 with 15 words buffered -> no wr_en. Raise init_end -> wr_en on the next cycle.
- Fill 512 words, send 2 more bytes -> overflow=1, fifo_level=512, dropped word never appears on wr_data. Same-cycle push and pop at full -> level stays 512, word accepted.
- Assert rst_n=0 during BUSY -> wr_en=0, wr_addr=0, fifo_level=0, overflow=0 asynchronously; a subsequent wr_end is ignored.
